int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
Memory-mapped interrupt controller sitting directly upstream of the CPU's interrupt logic. It latches device interrupt lines (timer, keys, switches) as pending events and applies a software mask and fixed priority. It presents a single request plus interrupt number to the core, then tracks the in-service interrupt until software signals end-of-interrupt. It attaches to the shared ABUS/RBUS/WBUS device bus like the other peripherals.

Parameters:
ABITS, 16, address bus width
DBITS, 16, data bus width
NSRC, 3, number of interrupt sources (max 14)
RBASE, 16'hFFD0, base address of the 8-byte register window

Ports:
CLK  in  1  system clock
INIT  in  1  synchronous active-high reset
LOCK  in  1  PLL lock; all state holds while low
ABUS  in  ABITS  bus address
RBUS  inout  DBITS  read bus; driven only on a selected read, else z
RE  in  1  bus read enable
WBUS  in  DBITS  bus write data
WE  in  1  bus write enable
IRQ_IN  in  NSRC  device interrupt lines; bit0 timer, bit1 keys, bit2 switches
ACK  in  1  one-cycle pulse: core has taken the interrupt
INTREQ  out  1  interrupt request to core
INTNUM  out  4  number of highest-priority request, 4'hF when none

Behaviour:
- Reset (INIT=1 at a rising edge): irq_q=0, PEND=0, MASK=all ones, INSVC=0, CUR=4'hF. Outputs: INTREQ=0, INTNUM=4'hF, RBUS=z.
- Edge detect: irq_q <= IRQ_IN each edge. A bit with IRQ_IN=1 and irq_q=0 sets PEND[i] at that edge. Level-held lines produce a single event.
- Latency: IRQ_IN rises before edge t. PEND sets at edge t. INTREQ is high in the cycle after edge t. No combinational path from IRQ_IN to INTREQ.
- act = PEND & MASK. INTREQ = |act && !INSVC.
- INTNUM = (lowest set index of act) + 1 when INTREQ, else 4'hF. Priority is fixed: lower index wins.
- ACK with INTREQ=1 at an edge:
  - clear the winning PEND bit
  - INSVC <= 1
  - CUR <= INTNUM
  - INTREQ drops the next cycle
- ACK with INTREQ=0: ignored.
- No nesting: while INSVC=1, new events still set PEND but INTREQ stays 0.
- Register window is RBASE..RBASE+7. Selected when ABUS[ABITS-1:3]==RBASE[ABITS-1:3]. Word offset is ABUS[2:1].
  - off0 PEND: read zero-extended. Write is write-1-to-clear.
  - off1 MASK: read/write; only low NSRC bits are stored.
  - off2 CUR: read {12'b0,CUR}. Any write is EOI: INSVC <= 0, CUR <= 4'hF.
  - off3 STAT: read {14'b0,INTREQ,INSVC}. Writes ignored.
- Reads are combinational: RBUS = reg value when RE && selected, else z.
- Writes take effect at the edge where WE && selected.
- Simultaneous events:
  - Edge-set and W1C or ACK-clear on the same bit in the same cycle: set wins.
  - EOI and ACK in the same cycle: ACK wins (INSVC=1, CUR=new).
  - A MASK write takes effect on INTREQ the next cycle.
- INIT mid-service discards all pending and in-service state.
- LOCK=0: no register updates; RBUS still obeys RE and select.

Decomposition:
- Package int_ctrl_pkg:
  - register offsets OFF_PEND=2'd0, OFF_MASK=2'd1, OFF_CUR=2'd2, OFF_STAT=2'd3
  - INTNUM_NONE=4'hF
  - source indices SRC_TIMER=0, SRC_KEYS=1, SRC_SWS=2
- One sub-module int_prio_enc: combinational NSRC-bit lowest-index priority encoder producing a valid flag and a 4-bit number (index+1).

Test Plan:
- Reset, then read STAT, PEND, MASK, CUR -> 0x0000, 0x0000, 0x0007, 0x000F; INTREQ=0, INTNUM=F.
- Pulse IRQ_IN=3'b010 before edge t -> INTREQ=1, INTNUM=2 in the cycle after edge t. ACK -> INTREQ=0, CUR=2, STAT=0x0001. Write CUR -> CUR=F, STAT=0.
- IRQ_IN=3'b111 in the same cycle -> INTNUM=1. ACK, EOI -> INTNUM=2. ACK, EOI -> INTNUM=3. Hold IRQ_IN high throughout -> no re-pend.
- Write MASK=0x0006, raise timer -> PEND=0x0001, INTREQ=0. Write MASK=0x0007 -> INTREQ=1 the next cycle, INTNUM=1.
- While INSVC=1, raise keys -> PEND=0x0002, INTREQ=0. In the same cycle as the keys edge, write PEND=0x0002 -> bit remains set. EOI -> INTREQ=1, INTNUM=2.
- Read ABUS=16'hFFD8 or a non-window address -> RBUS=z. INIT asserted with pending + INSVC -> all state returns to reset values the next cycle.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets inside the
// bus window, the "no interrupt" number and the source line assignments.
package int_ctrl_pkg;

   // Word offset within the 8-byte register window (ABUS[2:1]).
   typedef enum logic [1:0] {
      OFF_PEND = 2'd0,
      OFF_MASK = 2'd1,
      OFF_CUR  = 2'd2,
      OFF_STAT = 2'd3
   } reg_off_e;

   // Interrupt number presented when nothing is requested or in service.
   localparam logic [3:0] INTNUM_NONE = 4'hF;

   // Bit positions of the device lines on IRQ_IN.
   localparam int SRC_TIMER = 0;
   localparam int SRC_KEYS  = 1;
   localparam int SRC_SWS   = 2;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins and is reported
// as index+1, so that interrupt number 0 is never used and 4'hF means none.
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int NSRC = 3
) (
   input  logic [NSRC-1:0] i_req,
   output logic            o_valid,
   output logic [3:0]      o_num
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      // NOTE: both outputs get a default before the loop so every path assigns
      // them; a missing default here would infer a latch.
      o_valid = 1'b0;
      o_num   = INTNUM_NONE;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_num   = 4'(i + 1);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller. Device lines are edge-detected into
// PEND, filtered by MASK, and the lowest-numbered active source is offered to
// the core. Once the core acknowledges, the controller holds off further
// requests until software writes CUR (end-of-interrupt).
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int               ABITS = 16,
   parameter int               DBITS = 16,
   parameter int               NSRC  = 3,
   parameter logic [ABITS-1:0] RBASE = 16'hFFD0
) (
   input  logic             CLK,
   input  logic             INIT,
   input  logic             LOCK,
   input  logic [ABITS-1:0] ABUS,
   inout  wire  [DBITS-1:0] RBUS,
   input  logic             RE,
   input  logic [DBITS-1:0] WBUS,
   input  logic             WE,
   input  logic [NSRC-1:0]  IRQ_IN,
   input  logic             ACK,
   output logic             INTREQ,
   output logic [3:0]       INTNUM
);

   logic [NSRC-1:0]  r_irq_q;
   logic [NSRC-1:0]  r_pend;
   logic [NSRC-1:0]  r_mask;
   logic             r_insvc;
   logic [3:0]       r_cur;

   logic             w_sel;
   reg_off_e         w_off;
   logic             w_wr;
   logic             w_eoi;
   logic [NSRC-1:0]  w_act;
   logic             w_any;
   logic [3:0]       w_num;
   logic             w_take;
   logic [NSRC-1:0]  w_rise;
   logic [NSRC-1:0]  w_clr;
   logic [NSRC-1:0]  w_pend_nxt;
   logic [DBITS-1:0] w_rdata;
   logic             w_unused;

   // Address decode: window base on the upper bits, word offset on ABUS[2:1].
   assign w_sel = (ABUS[ABITS-1:3] == RBASE[ABITS-1:3]);
   assign w_off = reg_off_e'(ABUS[2:1]);
   assign w_wr  = WE && w_sel;
   assign w_eoi = w_wr && (w_off == OFF_CUR);

   // Byte-lane bit and the data bits above the widest register are not used.
   assign w_unused = ^{ABUS[0], WBUS[DBITS-1:NSRC]};

   assign w_act = r_pend & r_mask;

   int_prio_enc #(
      .NSRC (NSRC)
   ) u_prio_enc (
      .i_req   (w_act),
      .o_valid (w_any),
      .o_num   (w_num)
   );

   // Request is derived only from registered state, so IRQ_IN never reaches
   // INTREQ combinationally and a MASK write shows up one cycle later.
   assign INTREQ = w_any && !r_insvc;
   assign INTNUM = INTREQ ? w_num : INTNUM_NONE;
   assign w_take = ACK && INTREQ;

   assign w_rise = IRQ_IN & ~r_irq_q;

   // Collect PEND clears from a software W1C write and from the acknowledged winner.
   always_comb begin
      w_clr = '0;
      if (w_wr && (w_off == OFF_PEND)) begin
         w_clr = WBUS[NSRC-1:0];
      end
      for (int i = 0; i < NSRC; i++) begin
         if (w_take && (w_num == 4'(i + 1))) begin
            w_clr[i] = 1'b1;
         end
      end
   end

   // A new edge is OR-ed in after the clears so a same-cycle event is never lost.
   assign w_pend_nxt = (r_pend & ~w_clr) | w_rise;

   // Controller state: edge history, pending, mask and in-service tracking.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (INIT) begin
         r_irq_q <= '0;
         r_pend  <= '0;
         r_mask  <= '1;
         r_insvc <= 1'b0;
         r_cur   <= INTNUM_NONE;
      end else if (LOCK) begin
         r_irq_q <= IRQ_IN;
         r_pend  <= w_pend_nxt;
         if (w_wr && (w_off == OFF_MASK)) begin
            r_mask <= WBUS[NSRC-1:0];
         end
         // Acknowledge outranks an end-of-interrupt landing in the same cycle.
         if (w_take) begin
            r_insvc <= 1'b1;
            r_cur   <= w_num;
         end else if (w_eoi) begin
            r_insvc <= 1'b0;
            r_cur   <= INTNUM_NONE;
         end
      end
   end

   // Register read mux, zero-extended to the bus width.
   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_PEND: w_rdata[NSRC-1:0] = r_pend;
         OFF_MASK: w_rdata[NSRC-1:0] = r_mask;
         OFF_CUR:  w_rdata[3:0]      = r_cur;
         OFF_STAT: w_rdata[1:0]      = {INTREQ, r_insvc};
      endcase
   end

   // Shared read bus: drive only on a selected read, release otherwise.
   assign RBUS = (RE && w_sel) ? w_rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed walk through the main scenarios,
// then randomized traffic, all compared against a behavioural model of the
// controller kept in plain bit vectors and integer indices.
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   localparam int          NSRC   = 3;
   localparam logic [15:0] BASE   = 16'hFFD0;
   localparam logic [15:0] A_PEND = BASE;
   localparam logic [15:0] A_MASK = BASE + 16'd2;
   localparam logic [15:0] A_CUR  = BASE + 16'd4;
   localparam logic [15:0] A_STAT = BASE + 16'd6;
   localparam logic [15:0] FLOAT  = 16'hFFFF;  // pulled-up value of an undriven bus

   logic        clk = 1'b0;
   logic        init, lock, re, we, ack;
   logic [15:0] abus, wbus;
   logic [2:0]  irq;
   tri1  [15:0] rbus;
   logic        intreq;
   logic [3:0]  intnum;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   bit [2:0] m_pend, m_mask, m_irq_q;
   bit       m_insvc;
   bit [3:0] m_cur;
   bit       m_valid = 1'b0;

   always #5 clk = ~clk;

   int_ctrl dut (
      .CLK    (clk),
      .INIT   (init),
      .LOCK   (lock),
      .ABUS   (abus),
      .RBUS   (rbus),
      .RE     (re),
      .WBUS   (wbus),
      .WE     (we),
      .IRQ_IN (irq),
      .ACK    (ack),
      .INTREQ (intreq),
      .INTNUM (intnum)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Lowest index that is both pending and unmasked, or -1.
   function automatic int m_lowest();
      for (int i = 0; i < NSRC; i++) begin
         if (m_pend[i] && m_mask[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit m_req();
      return (m_lowest() >= 0) && !m_insvc;
   endfunction

   function automatic logic [3:0] m_num();
      return m_req() ? 4'(m_lowest() + 1) : INTNUM_NONE;
   endfunction

   function automatic bit in_window(input logic [15:0] a);
      return (a & 16'hFFF8) == BASE;
   endfunction

   function automatic int word_of(input logic [15:0] a);
      return int'((a >> 1) & 16'd3);
   endfunction

   function automatic logic [15:0] m_rbus();
      if (!(re && in_window(abus))) return FLOAT;
      case (word_of(abus))
         0:       return {13'd0, m_pend};
         1:       return {13'd0, m_mask};
         2:       return {12'd0, m_cur};
         default: return {14'd0, m_req(), m_insvc};
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      bit [2:0] nxt;
      int       win;
      bit       eoi;
      if (init) begin
         m_pend  = '0;
         m_mask  = '1;
         m_irq_q = '0;
         m_insvc = 1'b0;
         m_cur   = 4'hF;
         m_valid = 1'b1;
         return;
      end
      if (!lock) return;
      win = m_req() ? m_lowest() : -1;
      nxt = m_pend;
      eoi = 1'b0;
      if (we && in_window(abus)) begin
         case (word_of(abus))
            0:       nxt = nxt & ~wbus[2:0];
            1:       m_mask = wbus[2:0];
            2:       eoi = 1'b1;
            default: ;
         endcase
      end
      if (ack && win >= 0) begin
         nxt[win] = 1'b0;
         m_insvc  = 1'b1;
         m_cur    = 4'(win + 1);
      end else if (eoi) begin
         m_insvc = 1'b0;
         m_cur   = 4'hF;
      end
      nxt     = nxt | (irq & ~m_irq_q);
      m_pend  = nxt;
      m_irq_q = irq;
   endtask

   // Compare outputs against the model, then take one clock edge.
   task automatic clk_edge();
      #1;
      if (m_valid) begin
         check("intreq", 16'(intreq), 16'(m_req()));
         check("intnum", 16'(intnum), 16'(m_num()));
         check("rbus", rbus, m_rbus());
      end
      model_step();
      @(posedge clk);
      #1;
      ack  = 1'b0;
      we   = 1'b0;
      init = 1'b0;
      re   = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      abus = addr;
      re   = 1'b1;
      #1;
      check(tag, rbus, exp);
      clk_edge();
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
      abus = addr;
      wbus = data;
      we   = 1'b1;
      clk_edge();
   endtask

   task automatic expect_req(input string tag, input logic req, input logic [3:0] num);
      check({tag, "_req"}, 16'(intreq), 16'(req));
      check({tag, "_num"}, 16'(intnum), 16'(num));
   endtask

   initial begin
      init = 1'b1;
      lock = 1'b1;
      re   = 1'b0;
      we   = 1'b0;
      ack  = 1'b0;
      irq  = '0;
      abus = '0;
      wbus = '0;
      clk_edge();

      // Reset state.
      expect_req("rst", 1'b0, 4'hF);
      bus_read("rst_stat", A_STAT, 16'h0000);
      bus_read("rst_pend", A_PEND, 16'h0000);
      bus_read("rst_mask", A_MASK, 16'h0007);
      bus_read("rst_cur",  A_CUR,  16'h000F);

      // Single keys pulse, acknowledge, end-of-interrupt.
      irq = 3'b010;
      clk_edge();
      irq = 3'b000;
      expect_req("keys", 1'b1, 4'd2);
      ack = 1'b1;
      clk_edge();
      check("ack_drop", 16'(intreq), 16'd0);
      bus_read("ack_cur",  A_CUR,  16'h0002);
      bus_read("ack_stat", A_STAT, 16'h0001);
      bus_write(A_CUR, 16'h0000);
      bus_read("eoi_cur",  A_CUR,  16'h000F);
      bus_read("eoi_stat", A_STAT, 16'h0000);

      // All three at once, held high: served in priority order, no re-pend.
      irq = 3'b111;
      clk_edge();
      expect_req("all1", 1'b1, 4'd1);
      ack = 1'b1;
      clk_edge();
      bus_write(A_CUR, 16'h0000);
      expect_req("all2", 1'b1, 4'd2);
      ack = 1'b1;
      clk_edge();
      bus_write(A_CUR, 16'h0000);
      expect_req("all3", 1'b1, 4'd3);
      ack = 1'b1;
      clk_edge();
      bus_write(A_CUR, 16'h0000);
      expect_req("held", 1'b0, 4'hF);
      bus_read("held_pend", A_PEND, 16'h0000);
      irq = 3'b000;
      clk_edge();

      // Masked timer stays pending; unmasking raises the request next cycle.
      bus_write(A_MASK, 16'h0006);
      irq = 3'b001;
      clk_edge();
      irq = 3'b000;
      check("masked_req", 16'(intreq), 16'd0);
      bus_read("masked_pend", A_PEND, 16'h0001);
      bus_write(A_MASK, 16'h0007);
      expect_req("unmask", 1'b1, 4'd1);
      ack = 1'b1;
      clk_edge();
      bus_write(A_CUR, 16'h0000);

      // Keys edge while in service, colliding with a W1C of the same bit.
      irq = 3'b001;
      clk_edge();
      irq = 3'b000;
      ack = 1'b1;
      clk_edge();
      irq  = 3'b010;
      abus = A_PEND;
      wbus = 16'h0002;
      we   = 1'b1;
      clk_edge();
      irq = 3'b000;
      check("insvc_req", 16'(intreq), 16'd0);
      bus_read("setwins_pend", A_PEND, 16'h0002);
      bus_write(A_CUR, 16'h0000);
      expect_req("after_eoi", 1'b1, 4'd2);

      // ACK and EOI in the same cycle: the acknowledge takes effect.
      ack  = 1'b1;
      abus = A_CUR;
      wbus = 16'h0000;
      we   = 1'b1;
      clk_edge();
      bus_read("ackeoi_cur",  A_CUR,  16'h0002);
      bus_read("ackeoi_stat", A_STAT, 16'h0001);
      bus_write(A_CUR, 16'h0000);
      bus_read("clean_stat", A_STAT, 16'h0000);

      // Bus released outside the window and when not reading.
      bus_read("hole_ffd8", 16'hFFD8, FLOAT);
      bus_read("far_addr",  16'h1234, FLOAT);
      abus = A_MASK;
      re   = 1'b0;
      #1;
      check("re_low", rbus, FLOAT);
      clk_edge();

      // PLL unlocked: no updates, reads still served; edge seen after relock.
      lock = 1'b0;
      irq  = 3'b100;
      bus_write(A_MASK, 16'h0000);
      bus_read("lock_pend", A_PEND, 16'h0000);
      bus_read("lock_mask", A_MASK, 16'h0007);
      lock = 1'b1;
      clk_edge();
      irq = 3'b000;
      expect_req("relock", 1'b1, 4'd3);
      ack = 1'b1;
      clk_edge();
      bus_write(A_CUR, 16'h0000);

      // Reset in the middle of service discards everything.
      irq = 3'b011;
      clk_edge();
      irq = 3'b000;
      ack = 1'b1;
      clk_edge();
      bus_read("pre_init_stat", A_STAT, 16'h0001);
      init = 1'b1;
      clk_edge();
      expect_req("init", 1'b0, 4'hF);
      bus_read("init_pend", A_PEND, 16'h0000);
      bus_read("init_mask", A_MASK, 16'h0007);
      bus_read("init_cur",  A_CUR,  16'h000F);
      bus_read("init_stat", A_STAT, 16'h0000);

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         int r;
         irq  = 3'($urandom);
         ack  = ($urandom_range(0, 3) == 0);
         we   = ($urandom_range(0, 4) == 0);
         re   = 1'($urandom_range(0, 1));
         wbus = 16'($urandom);
         init = ($urandom_range(0, 199) == 0);
         lock = ($urandom_range(0, 15) != 0);
         r    = $urandom_range(0, 9);
         if (r < 8)       abus = BASE + 16'(r);
         else if (r == 8) abus = 16'hFFD8;
         else             abus = 16'($urandom);
         clk_edge();
      end
      lock = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
